fifo_beat_serializer: RTL and testbench

- Downstream consumer of the 512-bit staging FIFO. Pops whole 512-bit words through the FIFO's read/empty interface and serializes each into 64-bit beats, LSB-first, on a valid/ready stream toward the PHY encoder.
- A one-word prefetch register hides the FIFO's one-cycle read latency, so consecutive words stream with no bubble while the FIFO stays non-empty.

---
 rtl/fifo_beat_serializer.sv | 86 ++++++++
 tb/tb_fifo_beat_serializer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_beat_serializer.sv
// Pops 512-bit words from the staging FIFO and streams each one as 64-bit beats,
// least significant beat first, using a one-word prefetch so words follow each other without a bubble.
module fifo_beat_serializer #(
    parameter int unsigned IN_WIDTH  = 512,
    parameter int unsigned OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_read,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [IN_WIDTH-1:0] cur_word;
    logic [IN_WIDTH-1:0] pre_word;
    logic                cur_full;
    logic                pre_full;
    logic                rd_pending;
    logic [IDX_W-1:0]    beat_idx;

    logic beat_fire;
    logic word_done;

    assign beat_fire = cur_full && out_ready;
    assign word_done = beat_fire && (beat_idx == LAST_IDX);

    // Pop only when a slot is guaranteed for the word; reset suppresses pops so no word is silently lost.
    assign fifo_read = !reset && !fifo_empty && !rd_pending
                       && (!cur_full || !pre_full || (word_done && !pre_full));

    assign out_valid = cur_full;
    assign out_data  = cur_word[32'(OUT_WIDTH) * 32'(beat_idx) +: OUT_WIDTH];
    assign out_last  = cur_full && (beat_idx == LAST_IDX);
    assign busy      = cur_full | pre_full | rd_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_word   <= '0;
            pre_word   <= '0;
            cur_full   <= 1'b0;
            pre_full   <= 1'b0;
            rd_pending <= 1'b0;
            beat_idx   <= '0;
        end else begin
            rd_pending <= fifo_read;

            if (beat_fire) begin
                beat_idx <= word_done ? '0 : beat_idx + IDX_W'(1);
            end

            // Refill the output slot on word completion, otherwise park captured data in a free slot.
            if (word_done) begin
                if (pre_full) begin
                    cur_word <= pre_word;
                    if (rd_pending) begin
                        pre_word <= fifo_data;
                    end else begin
                        pre_full <= 1'b0;
                    end
                end else if (rd_pending) begin
                    cur_word <= fifo_data;
                end else begin
                    cur_full <= 1'b0;
                end
            end else if (rd_pending) begin
                if (!cur_full) begin
                    cur_word <= fifo_data;
                    cur_full <= 1'b1;
                end else begin
                    pre_word <= fifo_data;
                    pre_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_beat_serializer.sv
// Scoreboard bench for fifo_beat_serializer: a FIFO model feeds words, expected beats are queued on push
// and checked as the serializer hands them over.
module tb_fifo_beat_serializer;

    localparam int unsigned IN_W  = 512;
    localparam int unsigned OUT_W = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_empty = 1'b1;
    logic [IN_W-1:0]  fifo_data = '0;
    logic             fifo_read;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [IN_W-1:0]  fq[$];
    logic [OUT_W-1:0] exp_data[$];
    logic             exp_last[$];

    int reads = 0;
    int beats_seen = 0;
    int words_done = 0;
    int held = 0;
    int viol_empty = 0;
    int viol_consec = 0;
    int viol_held = 0;
    logic             prev_read = 1'b0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    fifo_beat_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, empty flag refreshed shortly after each edge.
    always @(posedge clk) begin
        if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
    end

    always @(posedge clk) begin
        #2;
        fifo_empty = (fq.size() == 0);
    end

    function automatic logic [OUT_W-1:0] beat_of(input int tag, input int k);
        logic [7:0] b;
        b = 8'((tag << 4) | (k + 1));
        return {8{b}};
    endfunction

    task automatic push_word(input int tag);
        logic [IN_W-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*OUT_W +: OUT_W] = beat_of(tag, k);
            exp_data.push_back(beat_of(tag, k));
            exp_last.push_back(k == 7);
        end
        fq.push_back(w);
    endtask

    // Output monitor: scoreboard compare, stall stability and read-protocol bookkeeping.
    always @(negedge clk) begin
        if (reset) begin
            held = 0;
            prev_valid = 1'b0;
            prev_read = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (fifo_read && fifo_empty) viol_empty++;
            if (fifo_read && prev_read) viol_consec++;
            if (fifo_read && held >= 2) viol_held++;
            if (fifo_read) begin
                reads++;
                held++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got unexpected beat %h expected none", out_data);
                end else begin
                    logic [OUT_W-1:0] d;
                    logic l;
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    if (out_data !== d || out_last !== l) begin
                        errors++;
                        $display("FAIL scoreboard: got d=%h l=%b expected d=%h l=%b",
                                 out_data, out_last, d, l);
                    end
                end
                beats_seen++;
                if (out_last) begin
                    words_done++;
                    held--;
                end
            end
            prev_read  = fifo_read;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic wait_drain(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_data.size() == 0 && !busy && fq.size() == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending expected 0 within %0d cycles",
                     name, exp_data.size(), budget);
        end
    endtask

    task automatic wait_beat(input string name, input int tag, input int k, output bit found);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_data == beat_of(tag, k)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_find_beat: got no beat %0d of word %0d expected it within 60 cycles",
                     name, k, tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fifo_read, out_valid, out_last, busy} !== 4'b0000 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got rd=%b v=%b l=%b busy=%b d=%h expected all 0",
                     fifo_read, out_valid, out_last, busy, out_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        int b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b0 = beats_seen;
        push_word(1);
        @(negedge clk);
        checks++;
        if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_read_issue: got rd=%b v=%b expected rd=1 v=0", fifo_read, out_valid);
        end
        @(negedge clk);
        checks++;
        if (fifo_read !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pending: got rd=%b v=%b busy=%b expected rd=0 v=0 busy=1",
                     fifo_read, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== beat_of(1, 0) || out_last !== 1'b0) begin
            errors++;
            $display("FAIL single_first_beat: got v=%b d=%h l=%b expected v=1 d=%h l=0",
                     out_valid, out_data, out_last, beat_of(1, 0));
        end
        wait_drain("single", 40);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || beats_seen - b0 != 8) begin
            errors++;
            $display("FAIL single_done: got busy=%b v=%b beats=%0d expected busy=0 v=0 beats=8",
                     busy, out_valid, beats_seen - b0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int gaps = 0;
        bit seen = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        r0 = reads;
        push_word(2);
        push_word(3);
        push_word(4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        for (int i = 0; i < 24; i++) begin
            if (!out_valid) gaps++;
            if (i < 23) @(negedge clk);
        end
        checks++;
        if (!seen || gaps != 0) begin
            errors++;
            $display("FAIL b2b_no_bubble: got seen=%b gaps=%0d expected seen=1 gaps=0", seen, gaps);
        end
        wait_drain("b2b", 40);
        checks++;
        if (reads - r0 != 3 || viol_consec != 0) begin
            errors++;
            $display("FAIL b2b_reads: got reads=%0d consec=%0d expected reads=3 consec=0",
                     reads - r0, viol_consec);
        end
    endtask

    task automatic test_stall();
        int w0;
        int b0;
        bit done = 0;
        logic [3:0] pat;
        pat = 4'b1001;
        @(posedge clk);
        #1;
        w0 = words_done;
        b0 = beats_seen;
        push_word(5);
        push_word(6);
        push_word(7);
        for (int i = 0; i < 300; i++) begin
            out_ready = pat[i % 4];
            @(posedge clk);
            #1;
            if (exp_data.size() == 0 && !busy && fq.size() == 0) begin
                done = 1;
                break;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (!done || words_done - w0 != 3 || beats_seen - b0 != 24) begin
            errors++;
            $display("FAIL stall_totals: got done=%b words=%0d beats=%0d expected done=1 words=3 beats=24",
                     done, words_done - w0, beats_seen - b0);
        end
        checks++;
        if (viol_held != 0) begin
            errors++;
            $display("FAIL stall_slots: got %0d reads with two words held expected 0", viol_held);
        end
    endtask

    task automatic test_empty_gap();
        int b0;
        int bad = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b0 = beats_seen;
        push_word(8);
        wait_drain("gap_first", 40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || fifo_read !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap_idle: got %0d active idle cycles expected 0", bad);
        end
        @(posedge clk);
        #1;
        push_word(9);
        wait_drain("gap_refill", 40);
        checks++;
        if (beats_seen - b0 != 16 || viol_empty != 0) begin
            errors++;
            $display("FAIL gap_refill: got beats=%0d rd_while_empty=%0d expected beats=16 rd_while_empty=0",
                     beats_seen - b0, viol_empty);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_word(10);
        push_word(11);
        push_word(12);
        wait_beat("rst_mid", 10, 3, found);
        reset = 1'b1;
        out_ready = 1'b0;
        fq.delete();
        exp_data.delete();
        exp_last.delete();
        @(negedge clk);
        checks++;
        if (fifo_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_read: got rd=%b expected 0", fifo_read);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_read, out_valid, out_last, busy} !== 4'b0000 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_cleared: got rd=%b v=%b l=%b busy=%b d=%h expected all 0",
                     fifo_read, out_valid, out_last, busy, out_data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_word(13);
        wait_drain("rst_mid", 40);
    endtask

    task automatic test_simultaneous();
        bit found;
        bit last_seen = 0;
        int b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b0 = beats_seen;
        push_word(14);
        wait_beat("simul", 14, 6, found);
        push_word(15);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                last_seen = 1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!last_seen || out_valid !== 1'b1 || out_data !== beat_of(15, 0)) begin
            errors++;
            $display("FAIL simul_handover: got last=%b v=%b d=%h expected last=1 v=1 d=%h",
                     last_seen, out_valid, out_data, beat_of(15, 0));
        end
        wait_drain("simul", 40);
        checks++;
        if (beats_seen - b0 != 16) begin
            errors++;
            $display("FAIL simul_count: got %0d beats expected 16", beats_seen - b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_empty_gap();
        test_reset_mid();
        test_simultaneous();
        checks++;
        if (viol_empty != 0 || viol_consec != 0 || viol_held != 0) begin
            errors++;
            $display("FAIL read_protocol: got empty=%0d consec=%0d held=%0d expected 0 0 0",
                     viol_empty, viol_consec, viol_held);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
